// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer that drives the external 8-bit ALU:
// data/opcode widths, opcode constants and the sequencer state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'h1;
    localparam logic [OP_W-1:0] OP_LSHIFT = 4'h2;
    localparam logic [OP_W-1:0] OP_RSHIFT = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR    = 4'h4;
    localparam logic [OP_W-1:0] OP_CMP    = 4'h5;
    localparam logic [OP_W-1:0] OP_AND    = 4'h6;
    localparam logic [OP_W-1:0] OP_NAND   = 4'h7;
    localparam logic [OP_W-1:0] OP_OR     = 4'h8;
    localparam logic [OP_W-1:0] OP_NOR    = 4'h9;
    localparam logic [OP_W-1:0] OP_CPY    = 4'hA;
    localparam logic [OP_W-1:0] OP_CLC    = 4'hB;
    localparam logic [OP_W-1:0] OP_SEC    = 4'hC;
    localparam logic [OP_W-1:0] OP_NOP    = 4'hD;  // 4'hE and 4'hF behave as NOP as well

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

    // Opcodes 0..A are executed by the external ALU; B..F are handled locally.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op <= OP_CPY);
    endfunction

endpackage

// File: rtl/alu_accu_ctrl.sv
// Accumulator sequencer: takes one instruction per handshake, drives the external ALU from
// registers, writes back accu/carry and returns the result. Optional zero flag: ALU_CTRL_ZFLAG_EN.
module alu_accu_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    // instr channel and res channel: a transfer happens on a rising edge where valid && ready;
    // valid never drops and its payload never changes until that transfer.
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_opcode,
    input  logic [DATA_W-1:0] instr_operand,
    output logic [DATA_W-1:0] alu_opA,
    output logic [DATA_W-1:0] alu_opB,
    output logic [OP_W-1:0]   alu_opcode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_outData,
    input  logic              alu_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic [DATA_W-1:0] accu,
`ifdef ALU_CTRL_ZFLAG_EN
    output logic              zero_flag,
`endif
    output logic [1:0]        state_dbg
);

    alu_state_e        state_q,     state_d;
    logic [OP_W-1:0]   op_q,        op_d;
    logic [DATA_W-1:0] accu_q,      accu_d;
    logic              carry_q,     carry_d;
    logic [DATA_W-1:0] res_data_q,  res_data_d;
    logic              res_carry_q, res_carry_d;
    logic [DATA_W-1:0] alu_opa_q,   alu_opa_d;
    logic [DATA_W-1:0] alu_opb_q,   alu_opb_d;
    logic [OP_W-1:0]   alu_op_q,    alu_op_d;
    logic              alu_cin_q,   alu_cin_d;
`ifdef ALU_CTRL_ZFLAG_EN
    logic              zero_q,      zero_d;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        accu_d      = accu_q;
        carry_d     = carry_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        alu_opa_d   = alu_opa_q;
        alu_opb_d   = alu_opb_q;
        alu_op_d    = alu_op_q;
        alu_cin_d   = alu_cin_q;
`ifdef ALU_CTRL_ZFLAG_EN
        zero_d      = zero_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d      = instr_opcode;
                    alu_cin_d = carry_q;
                    // The ALU shifts right on opB, so RSHIFT swaps the operands to shift accu.
                    if (instr_opcode == OP_RSHIFT) begin
                        alu_opa_d = instr_operand;
                        alu_opb_d = accu_q;
                    end else begin
                        alu_opa_d = accu_q;
                        alu_opb_d = instr_operand;
                    end
                    alu_op_d = is_alu_op(instr_opcode) ? instr_opcode : '0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d = accu_q;
                unique case (op_q)
                    OP_ADD, OP_SUB, OP_LSHIFT, OP_RSHIFT: begin
                        accu_d     = alu_outData;
                        carry_d    = alu_cout;
                        res_data_d = alu_outData;
                    end
                    OP_XOR, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_CPY: begin
                        accu_d     = alu_outData;
                        res_data_d = alu_outData;
                    end
                    OP_CMP: res_data_d = alu_outData;
                    OP_CLC: carry_d = 1'b0;
                    OP_SEC: carry_d = 1'b1;
                    default: ;
                endcase
`ifdef ALU_CTRL_ZFLAG_EN
                if (is_alu_op(op_q) && (op_q != OP_CMP)) begin
                    zero_d = (accu_d == '0);
                end
`endif
                res_carry_d = carry_d;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            accu_q      <= '0;
            carry_q     <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            alu_opa_q   <= '0;
            alu_opb_q   <= '0;
            alu_op_q    <= '0;
            alu_cin_q   <= 1'b0;
`ifdef ALU_CTRL_ZFLAG_EN
            zero_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            accu_q      <= accu_d;
            carry_q     <= carry_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            alu_opa_q   <= alu_opa_d;
            alu_opb_q   <= alu_opb_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
`ifdef ALU_CTRL_ZFLAG_EN
            zero_q      <= zero_d;
`endif
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_RESP);
    assign res_data    = res_data_q;
    assign res_carry   = res_carry_q;
    assign accu        = accu_q;
    assign alu_opA     = alu_opa_q;
    assign alu_opB     = alu_opb_q;
    assign alu_opcode  = alu_op_q;
    assign alu_cin     = alu_cin_q;
    assign state_dbg   = state_q;
`ifdef ALU_CTRL_ZFLAG_EN
    assign zero_flag   = zero_q;
`endif

endmodule
